// File: rtl/axis_pixels_halo_if.sv
// rtl/axis_pixels_halo_if.sv - input/output pixel stream bundle for axis_pixels_halo
interface axis_pixels_halo_if #(
    parameter int S_W = 40,
    parameter int M_W = 32
);
    logic           s_ready;
    logic           s_valid;
    logic           s_last;
    logic [S_W-1:0] s_data;
    logic           m_ready;
    logic           m_valid;
    logic           m_last;
    logic [1:0]     m_user;
    logic [M_W-1:0] m_data;

    // slave: the streamer itself; master: whatever feeds and drains it
    modport slave (
        output s_ready, m_valid, m_last, m_user, m_data,
        input  s_valid, s_last, s_data, m_ready
    );
    modport master (
        input  s_ready, m_valid, m_last, m_user, m_data,
        output s_valid, s_last, s_data, m_ready
    );
endinterface

// File: rtl/axis_pixels_halo.sv
// rtl/axis_pixels_halo.sv - vertical-halo pixel streamer
// Builds the KH-row window per beat from the previous block's edge (RAM) and the bottom halo.
module axis_pixels_halo #(
    parameter int ROWS            = 4,
    parameter int KH_MAX          = 3,
    parameter int CI_MAX          = 2,
    parameter int XW_MAX          = 4,
    parameter int XH_MAX          = 16,
    parameter int WORD_WIDTH      = 8,
    parameter int RAM_EDGES_DEPTH = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    axis_pixels_halo_if.slave  io
);
    localparam int EDGE_WORDS = KH_MAX / 2;
    localparam int S_WORDS    = ROWS + EDGE_WORDS;
    localparam int WIN_W      = (ROWS + 2 * EDGE_WORDS) * WORD_WIDTH;
    localparam int E_W        = EDGE_WORDS * WORD_WIDTH;
    localparam int BITS_KH2   = $clog2((KH_MAX + 1) / 2);
    localparam int BITS_CI    = $clog2(CI_MAX);
    localparam int BITS_XW    = $clog2(XW_MAX);
    localparam int BITS_L     = $clog2(XH_MAX / ROWS);
    localparam int ADDR_W     = $clog2(RAM_EDGES_DEPTH);
    localparam int KH_W       = BITS_KH2 + 1;
    localparam int O_CI       = BITS_KH2;
    localparam int O_XW       = O_CI + BITS_CI;
    localparam int O_L        = O_XW + BITS_XW;
    localparam int O_PAD      = O_L + BITS_L;

    typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [BITS_KH2-1:0]         kh2_q, kh2_d;
    logic [BITS_CI-1:0]          ci_max_q, ci_max_d, ci_q, ci_d;
    logic [BITS_XW-1:0]          w_max_q, w_max_d, w_q, w_d;
    logic [BITS_L-1:0]           l_max_q, l_max_d, l_q, l_d;
    logic [WORD_WIDTH-1:0]       pad_q, pad_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;

    logic                        a_valid_q, a_valid_d;
    logic [S_WORDS*WORD_WIDTH-1:0] a_data_q, a_data_d;
    logic [ADDR_W-1:0]           a_addr_q, a_addr_d;
    logic                        a_top_pad_q, a_top_pad_d;
    logic                        a_bot_pad_q, a_bot_pad_d;
    logic                        a_flast_q, a_flast_d;

    logic                        b_valid_q, b_valid_d;
    logic [WIN_W-1:0]            b_win_q, b_win_d;
    logic [KH_W-1:0]             b_kh_q, b_kh_d;
    logic                        b_flast_q, b_flast_d;

    logic [E_W-1:0]              mem_q [RAM_EDGES_DEPTH];
    logic [E_W-1:0]              dout_q, dout_d;

    logic            s_rdy, hdr_fire, dat_fire, last_kh, m_fire, b_free, a_move;
    logic            ci_wrap, w_wrap, l_wrap, ram_we, m_last_w;
    logic [E_W-1:0]  ram_wdata, edge_word, halo_word;
    logic [7:0]      off;
    logic [WIN_W-1:0] win_shift;

    always_comb begin
        last_kh  = (b_kh_q == {kh2_q, 1'b0});
        m_fire   = b_valid_q && io.m_ready;
        b_free   = !b_valid_q || (io.m_ready && last_kh);
        a_move   = a_valid_q && b_free;
        case (state_q)
            ST_HDR:  s_rdy = 1'b1;
            ST_DATA: s_rdy = !a_valid_q || a_move;
            default: s_rdy = 1'b0;
        endcase
        hdr_fire  = (state_q == ST_HDR) && io.s_valid;
        dat_fire  = (state_q == ST_DATA) && io.s_valid && s_rdy;
        ci_wrap   = (ci_q == ci_max_q);
        w_wrap    = (w_q == w_max_q);
        l_wrap    = (l_q == l_max_q);
        m_last_w  = b_valid_q && b_flast_q && last_kh;
        ram_we    = a_move && !a_bot_pad_q;
        ram_wdata = a_data_q[(ROWS-EDGE_WORDS)*WORD_WIDTH +: E_W];
        edge_word = a_top_pad_q ? {EDGE_WORDS{pad_q}} : dout_q;
        halo_word = a_bot_pad_q ? {EDGE_WORDS{pad_q}} : a_data_q[ROWS*WORD_WIDTH +: E_W];
        // Write-first bypass: a read that hits the row being written this cycle sees the new edge.
        dout_d    = dout_q;
        if (dat_fire)
            dout_d = (ram_we && (a_addr_q == addr_q)) ? ram_wdata : mem_q[addr_q];
        off       = 8'(EDGE_WORDS) - 8'(kh2_q) + 8'(b_kh_q);
        win_shift = b_win_q >> (32'(off) * 32'(WORD_WIDTH));
    end

    always_comb begin
        state_d  = state_q;
        kh2_d    = kh2_q;
        ci_max_d = ci_max_q;
        w_max_d  = w_max_q;
        l_max_d  = l_max_q;
        pad_d    = pad_q;
        ci_d     = ci_q;
        w_d      = w_q;
        l_d      = l_q;
        addr_d   = addr_q;
        case (state_q)
            ST_HDR:   if (hdr_fire) state_d = ST_DATA;
            ST_DATA:  if (dat_fire && io.s_last) state_d = ST_DRAIN;
            ST_DRAIN: if (m_fire && m_last_w) state_d = ST_HDR;
            default:  state_d = ST_HDR;
        endcase
        if (hdr_fire) begin
            kh2_d    = io.s_data[0 +: BITS_KH2];
            ci_max_d = io.s_data[O_CI +: BITS_CI];
            w_max_d  = io.s_data[O_XW +: BITS_XW];
            l_max_d  = io.s_data[O_L +: BITS_L];
            pad_d    = io.s_data[O_PAD +: WORD_WIDTH];
            ci_d     = '0;
            w_d      = '0;
            l_d      = '0;
            addr_d   = '0;
        end else if (dat_fire) begin
            ci_d   = ci_wrap ? '0 : ci_q + BITS_CI'(1);
            addr_d = (ci_wrap && w_wrap) ? '0 : addr_q + ADDR_W'(1);
            if (ci_wrap) w_d = w_wrap ? '0 : w_q + BITS_XW'(1);
            if (ci_wrap && w_wrap) l_d = l_wrap ? '0 : l_q + BITS_L'(1);
        end
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        a_data_d    = a_data_q;
        a_addr_d    = a_addr_q;
        a_top_pad_d = a_top_pad_q;
        a_bot_pad_d = a_bot_pad_q;
        a_flast_d   = a_flast_q;
        b_valid_d   = b_valid_q;
        b_win_d     = b_win_q;
        b_kh_d      = b_kh_q;
        b_flast_d   = b_flast_q;
        if (dat_fire) begin
            a_valid_d   = 1'b1;
            a_data_d    = io.s_data;
            a_addr_d    = addr_q;
            a_top_pad_d = (l_q == '0);
            a_bot_pad_d = l_wrap;
            a_flast_d   = ci_wrap && w_wrap && l_wrap;
        end else if (a_move) begin
            a_valid_d = 1'b0;
        end
        if (a_move) begin
            b_valid_d = 1'b1;
            b_win_d   = {halo_word, a_data_q[ROWS*WORD_WIDTH-1:0], edge_word};
            b_kh_d    = '0;
            b_flast_d = a_flast_q;
        end else if (m_fire) begin
            if (last_kh) begin
                b_valid_d = 1'b0;
                b_kh_d    = '0;
            end else begin
                b_kh_d = b_kh_q + KH_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (ram_we) mem_q[a_addr_q] <= ram_wdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_HDR;
            kh2_q       <= '0;
            ci_max_q    <= '0;
            w_max_q     <= '0;
            l_max_q     <= '0;
            pad_q       <= '0;
            ci_q        <= '0;
            w_q         <= '0;
            l_q         <= '0;
            addr_q      <= '0;
            a_valid_q   <= 1'b0;
            a_data_q    <= '0;
            a_addr_q    <= '0;
            a_top_pad_q <= 1'b0;
            a_bot_pad_q <= 1'b0;
            a_flast_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_win_q     <= '0;
            b_kh_q      <= '0;
            b_flast_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            kh2_q       <= kh2_d;
            ci_max_q    <= ci_max_d;
            w_max_q     <= w_max_d;
            l_max_q     <= l_max_d;
            pad_q       <= pad_d;
            ci_q        <= ci_d;
            w_q         <= w_d;
            l_q         <= l_d;
            addr_q      <= addr_d;
            a_valid_q   <= a_valid_d;
            a_data_q    <= a_data_d;
            a_addr_q    <= a_addr_d;
            a_top_pad_q <= a_top_pad_d;
            a_bot_pad_q <= a_bot_pad_d;
            a_flast_q   <= a_flast_d;
            b_valid_q   <= b_valid_d;
            b_win_q     <= b_win_d;
            b_kh_q      <= b_kh_d;
            b_flast_q   <= b_flast_d;
            dout_q      <= dout_d;
        end
    end

    assign io.s_ready = aresetn && s_rdy;
    assign io.m_valid = b_valid_q;
    assign io.m_last  = m_last_w;
    assign io.m_user  = b_valid_q ? {(b_kh_q == '0), last_kh} : 2'b00;
    assign io.m_data  = b_valid_q ? win_shift[ROWS*WORD_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_axis_pixels_halo.sv
// tb/tb_axis_pixels_halo.sv - directed self-checking bench for axis_pixels_halo
module tb_axis_pixels_halo;
    localparam int ROWS = 4, WW = 8, S_W = 40, M_W = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_pixels_halo_if #(.S_W(S_W), .M_W(M_W)) io ();

    axis_pixels_halo #(
        .ROWS(4), .KH_MAX(3), .CI_MAX(2), .XW_MAX(4), .XH_MAX(16),
        .WORD_WIDTH(8), .RAM_EDGES_DEPTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .io(io)
    );

    typedef struct packed {
        logic [M_W-1:0] data;
        logic [1:0]     user;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t prev_b;
    bit    stall_q = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    g_kh2, g_ci, g_w, g_l;
    logic [7:0] g_pad;
    bit    mr_rand = 1'b0;
    logic  mr_val = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        io.m_ready = mr_rand ? (int'($urandom_range(0, 99)) >= 30) : mr_val;
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stall_stable", 64'({io.m_valid, io.m_last, io.m_user, io.m_data}),
                    64'({1'b1, prev_b.last, prev_b.user, prev_b.data}));
            if (io.m_valid && io.m_ready)
                got_q.push_back('{data: io.m_data, user: io.m_user, last: io.m_last});
            stall_q = io.m_valid && !io.m_ready;
            prev_b  = '{data: io.m_data, user: io.m_user, last: io.m_last};
        end
    end

    function automatic logic [7:0] pix(int y, int w, int c);
        return 8'(16 * y + 4 * w + c + 1);
    endfunction

    function automatic logic [S_W-1:0] beat_data(int l, int w, int c);
        logic [S_W-1:0] d;
        for (int i = 0; i < ROWS; i++) d[i*WW +: WW] = pix(l * ROWS + i, w, c);
        d[ROWS*WW +: WW] = pix(l * ROWS + ROWS, w, c);
        return d;
    endfunction

    function automatic logic [S_W-1:0] hdr(int kh2, int ci, int w, int l, logic [7:0] pad);
        logic [S_W-1:0] d;
        d = '0;
        d[0]    = kh2[0];
        d[1]    = ci[0];
        d[3:2]  = w[1:0];
        d[5:4]  = l[1:0];
        d[13:6] = pad;
        return d;
    endfunction

    // Expected beats come straight from the image: output row r at tap kh is image row l*ROWS+r-kh2+kh.
    task automatic push_exp(int l, int w, int c);
        beat_t b;
        int y;
        for (int kh = 0; kh <= 2 * g_kh2; kh++) begin
            for (int r = 0; r < ROWS; r++) begin
                y = l * ROWS + r - g_kh2 + kh;
                b.data[r*WW +: WW] = (y < 0 || y >= (g_l + 1) * ROWS) ? g_pad : pix(y, w, c);
            end
            b.user = {kh == 0, kh == 2 * g_kh2};
            b.last = (l == g_l) && (w == g_w) && (c == g_ci) && (kh == 2 * g_kh2);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [S_W-1:0] d, input logic last);
        logic rdy;
        int n;
        io.s_valid = 1'b1;
        io.s_data  = d;
        io.s_last  = last;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 300) begin
            @(negedge aclk);
            rdy = io.s_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
        chk("s_accept", 64'(rdy), 64'd1);
    endtask

    task automatic send_frame(int kh2, int ci, int w, int l, logic [7:0] pad, int gap);
        g_kh2 = kh2; g_ci = ci; g_w = w; g_l = l; g_pad = pad;
        send_beat(hdr(kh2, ci, w, l, pad), 1'b0);
        for (int lb = 0; lb <= l; lb++)
            for (int wb = 0; wb <= w; wb++)
                for (int cb = 0; cb <= ci; cb++) begin
                    push_exp(lb, wb, cb);
                    if (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
                        @(posedge aclk);
                        #1;
                    end
                    send_beat(beat_data(lb, wb, cb), (lb == l) && (wb == w) && (cb == ci));
                end
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 4000) begin
            @(negedge aclk);
            n++;
        end
        repeat (5) @(negedge aclk);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
            chk({tag, "_user"}, 64'(got_q[i].user), 64'(exp_q[i].user));
            chk({tag, "_last"}, 64'(got_q[i].last), 64'(exp_q[i].last));
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
        io.s_data  = '0;
        repeat (3) @(negedge aclk);
        chk("rst_s_ready", 64'(io.s_ready), 64'd0);
        chk("rst_m_valid", 64'(io.m_valid), 64'd0);
        chk("rst_m_user",  64'(io.m_user),  64'd0);
        chk("rst_m_last",  64'(io.m_last),  64'd0);
        chk("rst_m_data",  64'(io.m_data),  64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("hdr_s_ready", 64'(io.s_ready), 64'd1);
        @(posedge aclk);
        #1;

        // basic frame: KH=3, two columns, two blocks, pad 0
        send_frame(1, 0, 1, 1, 8'h00, 0);
        collect("basic");
        if (got_q.size() == 12) begin
            chk("basic_top_pad",   64'(got_q[0].data[7:0]), 64'h00);
            chk("basic_top_edge",  64'(got_q[6].data[7:0]), 64'h31);
            chk("basic_last_11",   64'(got_q[10].last), 64'd0);
            chk("basic_last_12",   64'(got_q[11].last), 64'd1);
        end
        clear_q();

        // pad value on both halos; interior halos untouched
        send_frame(1, 1, 0, 1, 8'h7F, 0);
        collect("pad");
        if (got_q.size() == 12) begin
            chk("pad_top",       64'(got_q[0].data[7:0]),   64'h7F);
            chk("pad_bottom",    64'(got_q[11].data[31:24]), 64'h7F);
            chk("pad_int_top",   64'(got_q[6].data[7:0]),   64'h31);
            chk("pad_int_bot",   64'(got_q[2].data[31:24]), 64'h41);
        end
        clear_q();

        // latency of a single-beat KH=1 frame
        g_kh2 = 0; g_ci = 0; g_w = 0; g_l = 0; g_pad = 8'h00;
        send_beat(hdr(0, 0, 0, 0, 8'h00), 1'b0);
        push_exp(0, 0, 0);
        io.s_valid = 1'b1;
        io.s_data  = beat_data(0, 0, 0);
        io.s_last  = 1'b1;
        @(negedge aclk);
        chk("lat_s_ready", 64'(io.s_ready), 64'd1);
        @(posedge aclk);
        #1;
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
        @(negedge aclk);
        chk("lat_cycle1", 64'(io.m_valid), 64'd0);
        @(negedge aclk);
        chk("lat_cycle2", 64'(io.m_valid), 64'd1);
        collect("lat");
        clear_q();

        // KH=1 pass-through
        send_frame(0, 1, 1, 1, 8'h00, 0);
        collect("kh1");
        clear_q();

        // single column/channel: every edge read collides with the write
        send_frame(1, 0, 0, 2, 8'h55, 0);
        collect("bypass");
        clear_q();

        // random back-pressure on both sides
        mr_rand = 1'b1;
        send_frame(1, 1, 1, 2, 8'h11, 30);
        collect("bp");
        mr_rand = 1'b0;
        clear_q();

        // reset in the middle of a stalled frame
        mr_val = 1'b0;
        @(posedge aclk);
        #1;
        send_beat(hdr(1, 1, 1, 1, 8'h00), 1'b0);
        send_beat(beat_data(0, 0, 0), 1'b0);
        send_beat(beat_data(0, 0, 1), 1'b0);
        repeat (2) @(negedge aclk);
        chk("mid_m_valid", 64'(io.m_valid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_m_valid", 64'(io.m_valid), 64'd0);
        chk("mid_rst_s_ready", 64'(io.s_ready), 64'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        got_q.delete();
        mr_val = 1'b1;
        @(negedge aclk);
        chk("post_rst_s_ready", 64'(io.s_ready), 64'd1);
        @(posedge aclk);
        #1;

        // back-to-back frames with different KH
        send_frame(1, 0, 1, 1, 8'h00, 0);
        send_frame(0, 0, 1, 1, 8'h22, 0);
        collect("b2b");
        if (got_q.size() == 16)
            chk("b2b_frame1_end", 64'(got_q[11].last), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
